ifid_hazard: RTL and testbench

IFID_HAZARD -- requirements
Module: ifid_hazard

---
 rtl/ifid_hazard_pkg.sv | 15 +
 rtl/ifid_hazard_detect.sv | 37 +++
 rtl/ifid_hazard.sv | 73 +++++++
 tb/tb_ifid_hazard.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ifid_hazard_pkg.sv
// ifid_hazard_pkg: opcodes, NOP word, counter width and saturating increment
package ifid_hazard_pkg;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [31:0] NOP  = 32'h0;
    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction
endpackage

// File: rtl/ifid_hazard_detect.sv
// ifid_hazard_detect: combinational load-use and branch-operand hazard detection
module ifid_hazard_detect
    import ifid_hazard_pkg::*;
(
    input  logic [15:0] instr_hi,
    input  logic        validID,
    input  logic        MemReadEX,
    input  logic        RegWriteEX,
    input  logic [4:0]  RdEX,
    input  logic        MemReadMEM,
    input  logic [4:0]  RdMEM,
    output logic        stall
);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic usesRs, usesRt, isBranch, loadUse, brEX, brMEM;

    assign op = instr_hi[15:10];
    assign rs = instr_hi[9:5];
    assign rt = instr_hi[4:0];

    // $0 is hardwired, so a match against it is never a hazard
    function automatic logic match(input logic [4:0] rd);
        return (rd != 5'd0) && ((usesRs && rd == rs) || (usesRt && rd == rt));
    endfunction

    // decode source usage and evaluate the three hazard sources
    always_comb begin
        usesRs   = op != J;
        usesRt   = op == RTYPE || op == BEQ || op == BNE || op == SW;
        isBranch = op == BEQ || op == BNE;
        loadUse  = MemReadEX && match(RdEX);
        brEX     = isBranch && RegWriteEX && !MemReadEX && match(RdEX);
        brMEM    = isBranch && MemReadMEM && match(RdMEM);
        stall    = validID && (loadUse || brEX || brMEM);
    end
endmodule

// File: rtl/ifid_hazard.sv
// ifid_hazard: IF/ID pipeline register with stall, redirect flush and perf counters
module ifid_hazard
    import ifid_hazard_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      InstructionIF,
    input  logic [31:0]      PC4IF,
    input  logic             branchTakenID,
    input  logic             jumpID,
    input  logic             MemReadEX,
    input  logic             RegWriteEX,
    input  logic [4:0]       RdEX,
    input  logic             MemReadMEM,
    input  logic [4:0]       RdMEM,
    output logic [31:0]      InstructionID,
    output logic [31:0]      PC4ID,
    output logic             validID,
    output logic             PCWrite,
    output logic             flushIDEX,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);
    logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
    logic valid_q, valid_d, stall, flush;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    ifid_hazard_detect u_det (
        .instr_hi   (instr_q[31:16]),
        .validID    (valid_q),
        .MemReadEX  (MemReadEX),
        .RegWriteEX (RegWriteEX),
        .RdEX       (RdEX),
        .MemReadMEM (MemReadMEM),
        .RdMEM      (RdMEM),
        .stall      (stall)
    );

    // stall beats redirect: a stalled branch's operands are stale
    always_comb begin
        flush       = !stall && (branchTakenID || jumpID);
        instr_d     = stall ? instr_q : flush ? NOP : InstructionIF;
        pc4_d       = stall ? pc4_q : flush ? 32'h0 : PC4IF;
        valid_d     = stall ? valid_q : !flush;
        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // pipeline register and counters with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q     <= NOP;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign InstructionID = instr_q;
    assign PC4ID         = pc4_q;
    assign validID       = valid_q;
    assign PCWrite       = !stall;
    assign flushIDEX     = stall;
    assign stallCount    = stall_cnt_q;
    assign flushCount    = flush_cnt_q;
endmodule

// File: tb/tb_ifid_hazard.sv
// tb_ifid_hazard: directed and random checks against a spec-level reference model
module tb_ifid_hazard;
    logic clock = 0, reset = 0;
    logic [31:0] InstructionIF = 0, PC4IF = 0;
    logic branchTakenID = 0, jumpID = 0, MemReadEX = 0, RegWriteEX = 0, MemReadMEM = 0;
    logic [4:0] RdEX = 0, RdMEM = 0;
    logic [31:0] InstructionID, PC4ID;
    logic validID, PCWrite, flushIDEX;
    logic [15:0] stallCount, flushCount;

    int nchk = 0, nfail = 0;
    logic [31:0] m_ins = 0, m_pc = 0;
    logic m_val = 0;
    int m_sc = 0, m_fc = 0;

    ifid_hazard dut (
        .clock(clock), .reset(reset), .InstructionIF(InstructionIF), .PC4IF(PC4IF),
        .branchTakenID(branchTakenID), .jumpID(jumpID), .MemReadEX(MemReadEX),
        .RegWriteEX(RegWriteEX), .RdEX(RdEX), .MemReadMEM(MemReadMEM), .RdMEM(RdMEM),
        .InstructionID(InstructionID), .PC4ID(PC4ID), .validID(validID),
        .PCWrite(PCWrite), .flushIDEX(flushIDEX), .stallCount(stallCount), .flushCount(flushCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // does instruction ins read register rd (ignoring $0)?
    function automatic bit reads(input logic [31:0] ins, input logic [4:0] rd);
        int op = int'(ins[31:26]);
        bit rs_used = op != 2;
        bit rt_used = op == 0 || op == 4 || op == 5 || op == 43;
        return rd != 0 && ((rs_used && ins[25:21] == rd) || (rt_used && ins[20:16] == rd));
    endfunction

    function automatic bit ref_stall(input logic [31:0] ins, input bit v);
        int op = int'(ins[31:26]);
        bit br = op == 4 || op == 5;
        if (!v) return 0;
        if (MemReadEX && reads(ins, RdEX)) return 1;
        if (br && RegWriteEX && !MemReadEX && reads(ins, RdEX)) return 1;
        if (br && MemReadMEM && reads(ins, RdMEM)) return 1;
        return 0;
    endfunction

    task automatic step(input bit r, input logic [31:0] ins, input logic [31:0] pc, input bit bt,
                        input bit jp, input bit mre, input bit rwe, input logic [4:0] rde,
                        input bit mrm, input logic [4:0] rdm, input bit c);
        bit st;
        reset = r; InstructionIF = ins; PC4IF = pc; branchTakenID = bt; jumpID = jp;
        MemReadEX = mre; RegWriteEX = rwe; RdEX = rde; MemReadMEM = mrm; RdMEM = rdm;
        #1;
        st = ref_stall(m_ins, m_val);
        if (c) begin
            chk("PCWrite", {31'b0, PCWrite}, {31'b0, !st});
            chk("flushIDEX", {31'b0, flushIDEX}, {31'b0, st});
        end
        @(posedge clock);
        #1;
        if (r) begin
            m_ins = 0; m_pc = 0; m_val = 0; m_sc = 0; m_fc = 0;
        end else if (st) begin
            m_sc = m_sc < 65535 ? m_sc + 1 : 65535;
        end else if (bt || jp) begin
            m_ins = 0; m_pc = 0; m_val = 0;
            m_fc = m_fc < 65535 ? m_fc + 1 : 65535;
        end else begin
            m_ins = ins; m_pc = pc; m_val = 1;
        end
        if (c) begin
            chk("InstructionID", InstructionID, m_ins);
            chk("PC4ID", PC4ID, m_pc);
            chk("validID", {31'b0, validID}, {31'b0, m_val});
            chk("stallCount", {16'b0, stallCount}, m_sc[31:0]);
            chk("flushCount", {16'b0, flushCount}, m_fc[31:0]);
        end
    endtask

    task automatic idle(input logic [31:0] ins, input logic [31:0] pc);
        step(0, ins, pc, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic rst();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [5:0] ops [6] = '{6'd0, 6'd4, 6'd5, 6'd35, 6'd43, 6'd2};
        logic [31:0] ri;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst();
        idle(32'h1234_5678, 32'h4);
        chk("first_latency", InstructionID, 32'h1234_5678);

        // load-use: add $10,$8,$11 behind lw $8
        rst();
        idle(32'h010B5020, 32'h8);
        step(0, 32'hAAAA_0000, 32'hC, 0, 0, 1, 1, 8, 0, 0, 1);
        chk("lu_held", InstructionID, 32'h010B5020);
        chk("lu_count", {16'b0, stallCount}, 32'd1);
        step(0, 32'hAAAA_0000, 32'hC, 0, 0, 0, 0, 0, 1, 8, 1);
        chk("lu_resume", InstructionID, 32'hAAAA_0000);

        // beq $8,$9 after lw $8: loadUse then brMEM
        rst();
        idle(32'h11090004, 32'h10);
        step(0, 32'h0000_0020, 32'h14, 0, 0, 1, 1, 8, 0, 0, 1);
        step(0, 32'h0000_0020, 32'h14, 0, 0, 0, 0, 0, 1, 8, 1);
        chk("bl_held", InstructionID, 32'h11090004);
        step(0, 32'h0000_0020, 32'h14, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("bl_count", {16'b0, stallCount}, 32'd2);

        // taken branch with no hazard
        rst();
        idle(32'h11090004, 32'h10);
        step(0, 32'h0000_0020, 32'h14, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("tb_flush", {16'b0, flushCount}, 32'd1);
        step(0, 32'h0000_0020, 32'h14, 0, 1, 0, 0, 0, 0, 0, 1);
        chk("jump_flush", {16'b0, flushCount}, 32'd2);

        // brEX stall coincides with branchTaken: stall wins
        rst();
        idle(32'h11090004, 32'h10);
        step(0, 32'h0000_0020, 32'h14, 1, 0, 0, 1, 9, 0, 0, 1);
        chk("sim_nofl", {16'b0, flushCount}, 32'd0);
        step(0, 32'h0000_0020, 32'h14, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("sim_redir", {16'b0, flushCount}, 32'd1);

        // $0 immunity, then reset mid-stall
        rst();
        idle(32'h000B5020, 32'h18);
        step(0, 32'h0000_0020, 32'h1C, 0, 0, 1, 1, 0, 1, 0, 1);
        chk("zero_nostall", InstructionID, 32'h0000_0020);
        idle(32'h010B5020, 32'h20);
        step(0, 32'h0, 32'h0, 0, 0, 1, 1, 11, 0, 0, 1);
        step(1, 32'h0, 32'h0, 0, 0, 1, 1, 11, 0, 0, 1);
        chk("rst_mid", {31'b0, validID}, 32'd0);

        // random traffic with small register set to provoke matches
        for (int i = 0; i < 400; i++) begin
            ri = {ops[$urandom_range(0, 5)], 3'b0, 2'($urandom), 3'b0, 2'($urandom), 16'($urandom)};
            step($urandom_range(0, 49) == 0, ri, $urandom, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 1);
        end

        // saturation of stallCount under a permanent load-use stall
        rst();
        idle(32'h010B5020, 32'h8);
        for (int i = 0; i < 65540; i++) step(0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 1);
        chk("sat", {16'b0, stallCount}, 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end
endmodule
